prog_loader: RTL and testbench

Boot-time program loader that writes instruction memory from a byte stream. It is the writer side of the instruction-memory read port that the single-cycle CPU fetches from. It accepts a length-prefixed byte stream over a valid/ready handshake and packs the bytes into 32-bit big-endian words. It writes those words to consecutive word addresses starting at 0, and holds the CPU's PC in reset until the load completes.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/byte_packer.sv | 41 ++++
 rtl/prog_loader.sv | 129 ++++++++++++
 tb/tb_prog_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and sizing for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned LEN_W          = 8 * HDR_BYTES;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: shift register plus byte-in-word counter.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              pcrst,
  input  logic              shift_en,
  input  logic              clr,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              last_byte
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (shift_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // last_byte flags that the next accepted byte completes the word.
  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      word      <= '0;
      cnt_q     <= '0;
      last_byte <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      last_byte <= (cnt_d == CNT_W'(BYTES_PER_WORD - 1));
      if (shift_en) begin
        word <= {word[WORD_W-9:0], byte_in};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads instruction memory from a length-prefixed byte stream and holds the
// CPU in reset until the image is complete.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH_W = 6
) (
  input  logic        clk,
  input  logic        pcrst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W = DEPTH_W + 1;

  state_e           state_q;
  state_e           state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic [LEN_W-1:0] len_rx;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             xfer;
  logic             shift_en;
  logic             clr;
  logic             last_byte;

  assign xfer    = rx_valid & rx_ready;
  assign len_rx  = {len_q[LEN_W-1:8], rx_data};
  assign im_addr = 32'({idx_q, 2'b00});

  byte_packer u_packer (
    .clk       (clk),
    .pcrst     (pcrst),
    .shift_en  (shift_en),
    .clr       (clr),
    .byte_in   (rx_data),
    .word      (im_wdata),
    .last_byte (last_byte)
  );

  // Next-state, length and word-index update.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    shift_en = 1'b0;
    clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (xfer) begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d = len_rx;
          if (len_rx == '0) begin
            state_d = DONE;
          end else if (32'(len_rx) > (32'(1) << DEPTH_W)) begin
            state_d = ERR;
          end else begin
            idx_d   = '0;
            clr     = 1'b1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          shift_en = 1'b1;
          if (last_byte) state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_q + IDX_W'(1);
        if (LEN_W'(idx_q) + LEN_W'(1) == len_q) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end
      DONE, ERR: begin
        if (start) state_d = LEN_HI;
      end
      default: state_d = IDLE;
    endcase
  end

  // State/counter registers; status outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      rx_ready  <= 1'b0;
      im_we     <= 1'b0;
      cpu_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rx_ready  <= (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA);
      im_we     <= (state_d == WRITE);
      cpu_rst_n <= (state_d == DONE);
      busy      <= (state_d == LEN_HI) || (state_d == LEN_LO) ||
                   (state_d == DATA) || (state_d == WRITE);
      done      <= (state_d == DONE);
      err       <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of load scenarios against a
// memory-image model, plus reset and abort sequences.
module tb_prog_loader;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        pcrst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader #(.DEPTH_W(6)) dut (
    .clk       (clk),
    .pcrst     (pcrst),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] model_mem[DEPTH];
  logic [31:0] dut_mem[DEPTH];
  int          wcount;

  // Observe memory writes, check them in order and mirror them into a shadow image.
  always @(negedge clk) begin
    wr_t e;
    if (im_we === 1'b1) begin
      wcount++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", im_addr, e.addr);
        chk("write_data", im_wdata, e.data);
      end
      if (im_addr < 32'(4 * DEPTH)) dut_mem[im_addr[7:2]] = im_wdata;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int stall);
    int  t;
    bit  sent;
    sent = 1'b0;
    t    = 0;
    while (!sent && t < 1000) begin
      rx_data  = b;
      rx_valid = (int'($urandom_range(0, 99)) >= stall);
      @(negedge clk);
      sent = rx_valid && rx_ready;
      @(posedge clk);
      #1;
      t++;
    end
    rx_valid = 1'b0;
    if (!sent) chk("byte_accept_timeout", 32'(sent), 32'd1);
  endtask

  task automatic pulse_start(output int t0);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic mem_compare(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== model_mem[i]) bad++;
    chk(nm, 32'(bad), 32'd0);
  endtask

  typedef struct {
    int n;        // header word count
    int stall;    // percent of cycles with rx_valid low
    int dsel;     // 0 random words, 1 normal pattern, 2 single AABBCCDD
    bit exp_err;
    int exp_lat;  // start edge to done/err, -1 when stalls make it variable
  } row_t;

  row_t        rows[8];
  logic [31:0] w[DEPTH];

  initial begin
    int t0;
    int t;
    int nwr;
    bit merr;
    logic [15:0] n16;
    logic [31:0] a0;
    logic [31:0] a1;

    pcrst    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    wcount   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 32'h0;
      dut_mem[i]   = 32'h0;
    end

    rows[0] = '{n: 2,  stall: 0,  dsel: 1, exp_err: 1'b0, exp_lat: 12};
    rows[1] = '{n: 2,  stall: 50, dsel: 1, exp_err: 1'b0, exp_lat: -1};
    rows[2] = '{n: 0,  stall: 0,  dsel: 0, exp_err: 1'b0, exp_lat: 2};
    rows[3] = '{n: 65, stall: 0,  dsel: 0, exp_err: 1'b1, exp_lat: 2};
    rows[4] = '{n: 1,  stall: 0,  dsel: 2, exp_err: 1'b0, exp_lat: 7};
    rows[5] = '{n: 64, stall: 0,  dsel: 0, exp_err: 1'b0, exp_lat: 322};
    rows[6] = '{n: 5,  stall: 30, dsel: 0, exp_err: 1'b0, exp_lat: -1};
    rows[7] = '{n: 3,  stall: 0,  dsel: 0, exp_err: 1'b0, exp_lat: 17};

    // Reset values, and the CPU stays held while nothing starts a load.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", im_addr, 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    @(posedge clk);
    #1 pcrst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle_cpu_held", 32'(cpu_rst_n), 32'd0);
    chk("idle_state", {28'd0, rx_ready, busy, done, err}, 32'd0);

    foreach (rows[r]) begin
      merr = (rows[r].n > DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        case (rows[r].dsel)
          1:       w[i] = (i == 0) ? 32'h12345678 : 32'h9ABCDEF0;
          2:       w[i] = 32'hAABBCCDD;
          default: w[i] = $urandom;
        endcase
      end
      nwr = merr ? 0 : rows[r].n;
      for (int i = 0; i < nwr; i++) begin
        model_mem[i] = w[i];
        exp_q.push_back('{addr: 32'(4 * i), data: w[i]});
      end
      wcount = 0;
      n16 = 16'(rows[r].n);

      pulse_start(t0);
      send_byte(n16[15:8], rows[r].stall);
      send_byte(n16[7:0], rows[r].stall);
      for (int i = 0; i < nwr; i++) begin
        a0 = w[i];
        for (int k = 3; k >= 0; k--) send_byte(a0[8*k +: 8], rows[r].stall);
      end

      t = 0;
      @(negedge clk);
      while (!(done || err) && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("row%0d_finished", r), 32'(done | err), 32'd1);
      if (rows[r].exp_lat >= 0) chk($sformatf("row%0d_latency", r), 32'(cyc - t0), 32'(rows[r].exp_lat));
      chk($sformatf("row%0d_err", r), 32'(err), 32'(rows[r].exp_err));
      chk($sformatf("row%0d_done", r), 32'(done), 32'(!rows[r].exp_err));
      chk($sformatf("row%0d_cpu_rst_n", r), 32'(cpu_rst_n), 32'(!rows[r].exp_err));
      chk($sformatf("row%0d_idle_ports", r), {30'd0, rx_ready, busy}, 32'd0);
      chk($sformatf("row%0d_write_count", r), 32'(wcount), 32'(nwr));
      chk($sformatf("row%0d_pending_writes", r), 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      mem_compare($sformatf("row%0d_mem_image", r));
    end

    // Asynchronous reset from DONE: outputs clear with no clock edge.
    @(posedge clk);
    #3 pcrst = 1'b0;
    #1;
    chk("async_done", 32'(done), 32'd0);
    chk("async_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("async_im_addr", im_addr, 32'd0);
    chk("async_im_wdata", im_wdata, 32'd0);
    @(posedge clk);
    #1 pcrst = 1'b1;

    // Abort a 2-word load after 6 data bytes: only word 0 lands.
    a0 = $urandom;
    a1 = $urandom;
    model_mem[0] = a0;
    exp_q.push_back('{addr: 32'd0, data: a0});
    wcount = 0;
    pulse_start(t0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int k = 3; k >= 0; k--) send_byte(a0[8*k +: 8], 0);
    send_byte(a1[31:24], 0);
    send_byte(a1[23:16], 0);
    #2 pcrst = 1'b0;
    #1;
    chk("abort_write_count", 32'(wcount), 32'd1);
    chk("abort_state", {28'd0, rx_ready, busy, done, err}, 32'd0);
    chk("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    @(posedge clk);
    #1 pcrst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("abort_stays_idle", {27'd0, rx_ready, busy, done, err, cpu_rst_n}, 32'd0);
    chk("abort_pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    mem_compare("abort_mem_image");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
